// File: rtl/datapath.sv
// Registered N-bit two's-complement ALU: eight opcodes, result and carry/shift-out
// flag captured every rising clock edge.
module datapath #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   opcode,
  output logic [N-1:0] Y,
  output logic         co
);

  localparam int unsigned SW = $clog2(N);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpNot = 3'b101;
  localparam logic [2:0] OpShl = 3'b110;
  localparam logic [2:0] OpSra = 3'b111;

  logic [N-1:0]  y_d, y_q;
  logic          co_d, co_q;
  logic [SW-1:0] shamt;
  logic [N:0]    add_sum, sub_sum;
  logic [N:0]    shl_ext, sra_ext;

  assign shamt   = B[SW-1:0];
  assign add_sum = {1'b0, A} + {1'b0, B};
  assign sub_sum = {1'b0, A} + {1'b0, ~B} + {{N{1'b0}}, 1'b1};

  // One guard bit beyond the operand catches the last bit shifted out; a zero shift
  // leaves the guard bit at 0, which is the required flag value.
  assign shl_ext = {1'b0, A} << shamt;
  assign sra_ext = $unsigned($signed({A, 1'b0}) >>> shamt);

  always_comb begin
    y_d  = '0;
    co_d = 1'b0;
    case (opcode)
      OpAdd: begin
        y_d  = add_sum[N-1:0];
        co_d = add_sum[N];
      end
      OpSub: begin
        y_d  = sub_sum[N-1:0];
        co_d = sub_sum[N];
      end
      OpAnd: y_d = A & B;
      OpOr:  y_d = A | B;
      OpXor: y_d = A ^ B;
      OpNot: y_d = ~A;
      OpShl: begin
        y_d  = shl_ext[N-1:0];
        co_d = shl_ext[N];
      end
      OpSra: begin
        y_d  = sra_ext[N:1];
        co_d = sra_ext[0];
      end
      default: begin
        y_d  = '0;
        co_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q  <= '0;
      co_q <= 1'b0;
    end else begin
      y_q  <= y_d;
      co_q <= co_d;
    end
  end

  assign Y  = y_q;
  assign co = co_q;

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed cases, latency, async reset and a
// randomized run against an arithmetic reference model.
module tb_datapath;

  localparam int unsigned N = 16;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [2:0]   opcode;
  logic [N-1:0] Y;
  logic         co;

  int checks;
  int errors;

  datapath #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .opcode (opcode),
    .Y      (Y),
    .co     (co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model computed from the operation rules using plain integer arithmetic.
  function automatic void ref_model(input logic [15:0] a, input logic [15:0] b,
                                    input logic [2:0] op, output logic [15:0] y,
                                    output logic c);
    int unsigned ua;
    int unsigned ub;
    int unsigned s;
    int          sa;
    ua = a;
    ub = b;
    s  = b & 32'hF;
    sa = $signed(a);
    y  = '0;
    c  = 1'b0;
    case (op)
      3'd0: begin y = 16'(ua + ub); c = (ua + ub) >= 32'd65536; end
      3'd1: begin y = 16'(ua - ub); c = (ua >= ub); end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: y = ~a;
      3'd6: begin y = 16'(ua << s); c = (s == 0) ? 1'b0 : a[16 - s]; end
      default: begin y = 16'(sa >>> s); c = (s == 0) ? 1'b0 : a[s - 1]; end
    endcase
  endfunction

  // Drive inputs away from the edge, then sample just after the next rising edge.
  task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    @(negedge clk);
    A      = a;
    B      = b;
    opcode = op;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    A      = 16'd5;
    B      = 16'd3;
    opcode = 3'b000;
    #1;
    checks++;
    if (Y !== 16'd0 || co !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: Y=%h co=%b, required Y=0000 co=0", Y, co);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (Y !== 16'd0 || co !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: Y=%h co=%b, required Y=0000 co=0", i, Y, co);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (Y !== 16'd8 || co !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: Y=%h co=%b, required Y=0008 co=0", Y, co);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [15:0] y;
    logic        c;
  } vec_t;

  task automatic test_directed();
    vec_t v [13];
    v[0]  = '{16'd100,  16'hFFE2, 3'b000, 16'd70,   1'b1};
    v[1]  = '{16'd32767, 16'd1,   3'b000, 16'h8000, 1'b0};
    v[2]  = '{16'd5,    16'd7,    3'b001, 16'hFFFE, 1'b0};
    v[3]  = '{16'd7,    16'd5,    3'b001, 16'd2,    1'b1};
    v[4]  = '{16'h00F0, 16'h0FF0, 3'b010, 16'h00F0, 1'b0};
    v[5]  = '{16'h00F0, 16'h0FF0, 3'b011, 16'h0FF0, 1'b0};
    v[6]  = '{16'h00F0, 16'h0FF0, 3'b100, 16'h0F00, 1'b0};
    v[7]  = '{16'h00F0, 16'h0FF0, 3'b101, 16'hFF0F, 1'b0};
    v[8]  = '{16'h8001, 16'd1,    3'b110, 16'h0002, 1'b1};
    v[9]  = '{16'hFFF8, 16'd2,    3'b111, 16'hFFFE, 1'b0};
    v[10] = '{16'h0005, 16'd0,    3'b111, 16'h0005, 1'b0};
    v[11] = '{16'h8005, 16'd0,    3'b110, 16'h8005, 1'b0};
    v[12] = '{16'h4000, 16'd15,   3'b111, 16'h0000, 1'b1};
    for (int i = 0; i < 13; i++) begin
      apply(v[i].a, v[i].b, v[i].op);
      checks++;
      if (Y !== v[i].y || co !== v[i].c) begin
        errors++;
        $display("FAIL directed[%0d] op=%b: Y=%h co=%b, required Y=%h co=%b",
                 i, v[i].op, Y, co, v[i].y, v[i].c);
      end
    end
  endtask

  task automatic test_latency();
    apply(16'd1, 16'd1, 3'b000);
    checks++;
    if (Y !== 16'd2) begin
      errors++;
      $display("FAIL latency_first: Y=%h, required 0002", Y);
    end
    A = 16'd9;
    #2;
    checks++;
    if (Y !== 16'd2) begin
      errors++;
      $display("FAIL latency_hold: Y=%h, required 0002", Y);
    end
    @(posedge clk);
    #1;
    checks++;
    if (Y !== 16'd10) begin
      errors++;
      $display("FAIL latency_next: Y=%h, required 000a", Y);
    end
  endtask

  task automatic test_reset_midop();
    apply(16'h7FFF, 16'h7FFF, 3'b000);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (Y !== 16'd0 || co !== 1'b0) begin
      errors++;
      $display("FAIL reset_midop: Y=%h co=%b, required Y=0000 co=0", Y, co);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [15:0] a, b, ey;
    logic [2:0]  op;
    logic        ec;
    for (int i = 0; i < 300; i++) begin
      a  = 16'($urandom);
      b  = 16'($urandom);
      op = 3'($urandom_range(0, 7));
      apply(a, b, op);
      ref_model(a, b, op, ey, ec);
      checks++;
      if (Y !== ey || co !== ec) begin
        errors++;
        $display("FAIL random[%0d] A=%h B=%h op=%b: Y=%h co=%b, required Y=%h co=%b",
                 i, a, b, op, Y, co, ey, ec);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_latency();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
